// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART responder with TX/RX FIFOs, sticky status bits and a
// runtime baud divisor. Register index is A[4:2]; all state changes on rising clk.
module mmio_uart #(
  parameter int DIV_RESET = 868,
  parameter int FIFO_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] RD,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  typedef logic [FIFO_LOG2:0] ptr_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [2:0] w_idx;
  logic       w_tx_wr, w_st_wr, w_div_wr, w_unused;
  assign w_idx    = A[4:2];
  assign w_tx_wr  = WE && (w_idx == 3'd0);
  assign w_st_wr  = WE && (w_idx == 3'd2);
  assign w_div_wr = WE && (w_idx == 3'd3);
  assign w_unused = ^{A[1:0], WD[31:16]};

  logic [15:0] r_div;
  logic        r_tx_ovf, r_rx_ovf, r_fe;

  // ---------------- TX FIFO ----------------
  logic [7:0] r_txmem [DEPTH];
  ptr_t       r_txwp, r_txrp;
  logic       w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_txovf_set;
  assign w_tx_empty  = (r_txwp == r_txrp);
  assign w_tx_full   = (r_txwp[FIFO_LOG2] != r_txrp[FIFO_LOG2]) &&
                       (r_txwp[FIFO_LOG2-1:0] == r_txrp[FIFO_LOG2-1:0]);
  // A pop in the same edge frees the slot, so a write to a full FIFO still lands.
  assign w_tx_push   = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign w_txovf_set = w_tx_wr && w_tx_full && !w_tx_pop;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_txmem[r_txwp[FIFO_LOG2-1:0]] <= WD[7:0];
    if (!rst_n) begin
      r_txwp <= '0;
      r_txrp <= '0;
    end else begin
      if (w_tx_push) r_txwp <= r_txwp + ptr_t'(1);
      if (w_tx_pop)  r_txrp <= r_txrp + ptr_t'(1);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t   r_tx_st, w_tx_nxt;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        r_tx, w_tx_tick;
  assign w_tx_tick = (r_tx_cnt == r_tx_div - 16'd1);

  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE:  if (!w_tx_empty) begin w_tx_nxt = TX_START; w_tx_pop = 1'b1; end
      TX_START: if (w_tx_tick) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
                  if (!w_tx_empty) begin w_tx_nxt = TX_START; w_tx_pop = 1'b1; end
                  else w_tx_nxt = TX_IDLE;
                end
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_st  <= TX_IDLE;
      r_tx     <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_div <= DIV_RESET[15:0];
    end else begin
      r_tx_st <= w_tx_nxt;
      if (w_tx_pop) begin
        r_tx_sh  <= r_txmem[r_txrp[FIFO_LOG2-1:0]];
        r_tx     <= 1'b0;
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        r_tx_div <= r_div;
      end else if (r_tx_st != TX_IDLE) begin
        if (w_tx_tick) begin
          r_tx_cnt <= '0;
          if (r_tx_st == TX_STOP || (r_tx_st == TX_DATA && r_tx_bit == 3'd7)) r_tx <= 1'b1;
          else begin
            r_tx    <= r_tx_sh[0];
            r_tx_sh <= r_tx_sh >> 1;
          end
          if (r_tx_st == TX_DATA) r_tx_bit <= r_tx_bit + 3'd1;
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- RX path ----------------
  rx_state_t   r_rx_st, w_rx_nxt;
  logic        r_rx_s1, r_rx_s2, w_rx_half, w_rx_tick, w_rx_push, w_fe_set;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
  assign w_rx_tick = (r_rx_cnt == r_rx_div - 16'd1);

  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_rx_push = 1'b0;
    w_fe_set  = 1'b0;
    case (r_rx_st)
      RX_IDLE:  if (!r_rx_s2) w_rx_nxt = RX_START;
      RX_START: if (w_rx_half) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
                  if (r_rx_s2) begin w_rx_push = 1'b1; w_rx_nxt = RX_IDLE; end
                  else begin w_fe_set = 1'b1; w_rx_nxt = RX_WAIT; end
                end
      RX_WAIT:  if (r_rx_s2) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_div <= DIV_RESET[15:0];
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_st <= w_rx_nxt;
      case (r_rx_st)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
          r_rx_div <= r_div;
        end
        RX_START: r_rx_cnt <= w_rx_half ? 16'd0 : r_rx_cnt + 16'd1;
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + 16'd1;
        end
        RX_STOP: r_rx_cnt <= w_rx_tick ? 16'd0 : r_rx_cnt + 16'd1;
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0] r_rxmem [DEPTH];
  ptr_t       r_rxwp, r_rxrp;
  logic       w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_rxovf_set;
  assign w_rx_empty  = (r_rxwp == r_rxrp);
  assign w_rx_full   = (r_rxwp[FIFO_LOG2] != r_rxrp[FIFO_LOG2]) &&
                       (r_rxwp[FIFO_LOG2-1:0] == r_rxrp[FIFO_LOG2-1:0]);
  assign w_rx_pop    = RE && (w_idx == 3'd1) && !w_rx_empty;
  assign w_rx_wr     = w_rx_push && (!w_rx_full || w_rx_pop);
  assign w_rxovf_set = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rxmem[r_rxwp[FIFO_LOG2-1:0]] <= r_rx_sh;
    if (!rst_n) begin
      r_rxwp <= '0;
      r_rxrp <= '0;
    end else begin
      if (w_rx_wr)  r_rxwp <= r_rxwp + ptr_t'(1);
      if (w_rx_pop) r_rxrp <= r_rxrp + ptr_t'(1);
    end
  end

  // Sticky bits: a set in the same edge as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_fe     <= 1'b0;
      r_div    <= DIV_RESET[15:0];
    end else begin
      r_tx_ovf <= w_txovf_set | (r_tx_ovf & ~(w_st_wr & WD[5]));
      r_rx_ovf <= w_rxovf_set | (r_rx_ovf & ~(w_st_wr & WD[6]));
      r_fe     <= w_fe_set    | (r_fe     & ~(w_st_wr & WD[7]));
      if (w_div_wr) r_div <= (WD[15:0] < 16'd4) ? 16'd4 : WD[15:0];
    end
  end

  always_comb begin
    RD = '0;
    case (w_idx)
      3'd1: if (!w_rx_empty) RD = {24'b0, r_rxmem[r_rxrp[FIFO_LOG2-1:0]]};
      3'd2: RD = {24'b0, r_fe, r_rx_ovf, r_tx_ovf, (r_tx_st != TX_IDLE),
                  w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
      3'd3: RD = {16'b0, r_div};
      default: RD = '0;
    endcase
  end

  assign tx  = r_tx;
  assign irq = !w_rx_empty;
endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register-access vector table plus serial
// TX/RX sequences at 16 clks/bit.
module tb_mmio_uart;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE, RE;
  logic [31:0] RD;
  logic        rx;
  logic        tx;
  logic        irq;

  mmio_uart dut (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RE(RE),
    .RD(RD), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vt[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    A = a;
    #1 v = RD;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Serial monitor on tx: samples mid-bit at 16 clks/bit.
  logic       mon_en = 1'b0;
  logic [7:0] mon_b;
  int         mon_stop_bad = 0;
  logic [7:0] mon_q[$];
  initial forever begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (16) @(negedge clk);
      if (tx !== 1'b1) mon_stop_bad++;
      mon_q.push_back(mon_b);
    end
  end

  logic [31:0] v;
  logic [161:0] txs, busys;
  logic [9:0]  fr;

  initial begin
    rst_n = 1'b0; rx = 1'b1; A = '0; WD = '0; WE = 1'b0; RE = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);

    vt[0]  = '{5'd8,  32'h0,       1'b0, 1'b0, 1'b1, 32'h06,   "rst_status"};
    vt[1]  = '{5'd12, 32'h0,       1'b0, 1'b0, 1'b1, 32'd868,  "rst_baud"};
    vt[2]  = '{5'd0,  32'h0,       1'b0, 1'b0, 1'b1, 32'h0,    "txdata_rd"};
    vt[3]  = '{5'd4,  32'h0,       1'b0, 1'b1, 1'b1, 32'h0,    "rxdata_empty"};
    vt[4]  = '{5'd16, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,    "idx4_rd"};
    vt[5]  = '{5'd28, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0,    "idx7_rd"};
    vt[6]  = '{5'd12, 32'd3,       1'b1, 1'b0, 1'b0, 32'h0,    "baud_wr3"};
    vt[7]  = '{5'd12, 32'h0,       1'b0, 1'b0, 1'b1, 32'd4,    "baud_min4"};
    vt[8]  = '{5'd12, 32'h12345,   1'b1, 1'b0, 1'b0, 32'h0,    "baud_wrbig"};
    vt[9]  = '{5'd12, 32'h0,       1'b0, 1'b0, 1'b1, 32'h2345, "baud_16bit"};
    vt[10] = '{5'd16, 32'hFFFF,    1'b1, 1'b0, 1'b0, 32'h0,    "idx4_wr"};
    vt[11] = '{5'd14, 32'h0,       1'b0, 1'b0, 1'b1, 32'h2345, "baud_a10_ign"};
    vt[12] = '{5'd15, 32'd16,      1'b1, 1'b0, 1'b0, 32'h0,    "baud_wr16"};
    vt[13] = '{5'd12, 32'h0,       1'b0, 1'b0, 1'b1, 32'd16,   "baud_16"};
    vt[14] = '{5'd8,  32'hFF,      1'b1, 1'b0, 1'b0, 32'h0,    "status_wr"};
    vt[15] = '{5'd8,  32'h0,       1'b0, 1'b0, 1'b1, 32'h06,   "status_ro"};
    vt[16] = '{5'd0,  32'h0,       1'b0, 1'b0, 1'b1, 32'h0,    "txdata_rd2"};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      A = vt[i].a; WD = vt[i].wd; WE = vt[i].we; RE = vt[i].re;
      #1;
      if (vt[i].chk) check(vt[i].nm, RD, vt[i].exp);
      @(negedge clk);
    end
    WE = 1'b0; RE = 1'b0;
    check("tbl_tx_idle", {31'b0, tx}, 32'd1);
    mon_en = 1'b1;

    // 1: exact TX waveform of 0xA5
    wr(5'd0, 32'hA5);
    A = 5'd8;
    for (int k = 0; k < 162; k++) begin
      #1;
      txs[k] = tx;
      busys[k] = RD[4];
      @(negedge clk);
    end
    fr = {1'b1, 8'hA5, 1'b0};
    check("t1_idle_k0", {31'b0, txs[0]}, 32'd1);
    for (int s = 0; s < 10; s++) begin
      check($sformatf("t1_slot%0d_first", s), {31'b0, txs[1 + 16*s]}, {31'b0, fr[s]});
      check($sformatf("t1_slot%0d_last", s), {31'b0, txs[16 + 16*s]}, {31'b0, fr[s]});
    end
    check("t1_busy_160", {31'b0, busys[160]}, 32'd1);
    check("t1_busy_161", {31'b0, busys[161]}, 32'd0);
    check("t1_tx_161", {31'b0, txs[161]}, 32'd1);

    // 2: 9 back-to-back bytes all sent, 10th dropped
    repeat (20) @(negedge clk);
    mon_q.delete();
    for (int i = 0; i < 9; i++) wr(5'd0, 32'h30 + i);
    wr(5'd0, 32'hEE);
    rd(5'd8, v);
    check("t2_tx_ovf", {31'b0, v[5]}, 32'd1);
    check("t2_tx_full", {31'b0, v[0]}, 32'd1);
    for (int c = 0; c < 2000 && mon_q.size() < 9; c++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("t2_count", mon_q.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < mon_q.size()) check($sformatf("t2_byte%0d", i), {24'b0, mon_q[i]}, 32'h30 + i);
    check("t2_stop_bits", mon_stop_bad, 32'd0);
    wr(5'd8, 32'h20);
    rd(5'd8, v);
    check("t2_w1c", v, 32'h06);
    mon_en = 1'b0;

    // 3: receive 0x3C, pop
    send_rx(8'h3C, 1'b1);
    check("t3_irq", {31'b0, irq}, 32'd1);
    rd(5'd4, v);
    check("t3_rxdata", v, 32'h3C);
    RE = 1'b1;
    @(negedge clk);
    RE = 1'b0;
    #1;
    check("t3_irq_pop", {31'b0, irq}, 32'd0);
    rd(5'd8, v);
    check("t3_rx_empty", {31'b0, v[2]}, 32'd1);

    // 4: frame error, then W1C
    send_rx(8'h5A, 1'b0);
    rd(5'd8, v);
    check("t4_fe", v, 32'h86);
    check("t4_irq", {31'b0, irq}, 32'd0);
    wr(5'd8, 32'h80);
    rd(5'd8, v);
    check("t4_fe_clr", v, 32'h06);

    // 5: glitch rejected, then RX overflow
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd(5'd8, v);
    check("t5_glitch", v, 32'h06);
    check("t5_glitch_irq", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) send_rx(8'hC0 + 8'(i), 1'b1);
    send_rx(8'hEE, 1'b1);
    rd(5'd8, v);
    check("t5_ovf_status", v, 32'h4A);
    for (int i = 0; i < 8; i++) begin
      A = 5'd4; RE = 1'b1;
      #1 check($sformatf("t5_pop%0d", i), RD, 32'hC0 + i);
      @(negedge clk);
      RE = 1'b0;
    end
    rd(5'd8, v);
    check("t5_after_pops", v, 32'h46);

    // 6: reset mid-frame
    wr(5'd0, 32'h55);
    wr(5'd0, 32'h66);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("t6_tx_rst", {31'b0, tx}, 32'd1);
    rd(5'd8, v);
    check("t6_status", v, 32'h06);
    rst_n = 1'b1;
    rd(5'd12, v);
    check("t6_baud", v, 32'd868);
    repeat (20) @(negedge clk);
    check("t6_tx_quiet", {31'b0, tx}, 32'd1);
    wr(5'd12, 32'd2);
    rd(5'd12, v);
    check("t6_baud_min", v, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
